// File: rtl/fht_pkg.sv
// Shared constants and the loader state encoding for the FHT front end.
package fht_pkg;

  localparam int N_POINTS  = 1024;
  localparam int LOG2_N    = 10;
  localparam int N_BANK    = 4;
  localparam int A_BIT_DEF = 8;
  localparam int D_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    START,
    WAIT_ACK,
    WAIT_DONE
  } ld_state_e;

endpackage

// File: rtl/fht_bitrev.sv
// Combinational bit reversal of a W-bit word: out_data[i] = in_data[W-1-i].
// Shared between the input loader and the output unloader.
module fht_bitrev #(
  parameter int W = 10
) (
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data
);

  // Pure wiring: mirror every bit position.
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign out_data[i] = in_data[W-1-i];
  end

endmodule

// File: rtl/fht_input_loader.sv
// FHT input loader: accepts one frame of 2^N_BIT samples over valid/ready,
// scatters them over four RAM banks, pulses the FHT start, then waits for
// the transform to finish before accepting the next frame.
// Build option FHT_LOADER_BITREV_EN: defined selects the bit-reversed scatter,
// undefined selects natural order (input already reversed upstream).
module fht_input_loader
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF,
  parameter int D_BIT = D_BIT_DEF,
  parameter int N_BIT = LOG2_N
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic             oSTART,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic             oWE_0,
  output logic             oWE_1,
  output logic             oWE_2,
  output logic             oWE_3,
  output logic             oBUSY,
  output logic [7:0]       oFRAME_CNT
);

  ld_state_e          state_q, state_d;
  logic [N_BIT-1:0]   idx_q, idx_d;
  logic [N_BIT-1:0]   map_idx;
  logic [N_BANK-1:0]  we_q, we_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic [7:0]         frame_q, frame_d;
  logic               xfer;

  // Index-to-location map: low two bits pick the bank, the rest is the word.
`ifdef FHT_LOADER_BITREV_EN
  fht_bitrev #(.W(N_BIT)) u_bitrev (
    .in_data  (idx_q),
    .out_data (map_idx)
  );
`else
  assign map_idx = idx_q;
`endif

  assign oREADY     = (state_q == LOAD);
  assign oBUSY      = (state_q != LOAD);
  assign oSTART     = (state_q == START);
  assign xfer       = iVALID & oREADY;
  assign oADDR_WR   = addr_q;
  assign oDATA_WR   = data_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oFRAME_CNT = frame_q;

  // Next-state and write-port logic; write strobes last a single cycle and
  // address/data hold their last value between writes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (iFHT_RDY) state_d = LOAD;
      end
      LOAD: begin
        if (xfer) begin
          idx_d              = idx_q + 1'b1;
          we_d[map_idx[1:0]] = 1'b1;
          addr_d             = A_BIT'(map_idx >> 2);
          data_d             = iDATA;
          if (idx_q == '1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = START;
      end
      START: begin
        frame_d = frame_q + 8'd1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!iFHT_RDY) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (iFHT_RDY) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: full-size instance for the data path
// and handshake, plus a 16-point instance for the frame counter wrap.
module tb_fht_input_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, fht_rdy;
  logic [15:0] din;
  logic        ready, start, busy, we0, we1, we2, we3;
  logic [7:0]  addr, fcnt;
  logic [15:0] dwr;

  logic        s_valid, s_fht;
  logic [15:0] s_data;
  logic        s_ready, s_start, s_busy, s_we0, s_we1, s_we2, s_we3;
  logic [1:0]  s_addr;
  logic [15:0] s_dwr;
  logic [7:0]  s_fcnt;

  fht_input_loader dut (
    .iCLK(clk), .iRESET(rst_n), .iDATA(din), .iVALID(valid), .oREADY(ready),
    .iFHT_RDY(fht_rdy), .oSTART(start), .oADDR_WR(addr), .oDATA_WR(dwr),
    .oWE_0(we0), .oWE_1(we1), .oWE_2(we2), .oWE_3(we3), .oBUSY(busy),
    .oFRAME_CNT(fcnt)
  );

  fht_input_loader #(.A_BIT(2), .D_BIT(16), .N_BIT(4)) dut_s (
    .iCLK(clk), .iRESET(rst_n), .iDATA(s_data), .iVALID(s_valid), .oREADY(s_ready),
    .iFHT_RDY(s_fht), .oSTART(s_start), .oADDR_WR(s_addr), .oDATA_WR(s_dwr),
    .oWE_0(s_we0), .oWE_1(s_we1), .oWE_2(s_we2), .oWE_3(s_we3), .oBUSY(s_busy),
    .oFRAME_CNT(s_fcnt)
  );

`ifdef FHT_LOADER_BITREV_EN
  localparam int I1_BANK = 0, I1_ADDR = 128, I2_BANK = 0, I2_ADDR = 64;
  localparam int I4_BANK = 0, I4_ADDR = 32, I512_BANK = 1, I512_ADDR = 0;
`else
  localparam int I1_BANK = 1, I1_ADDR = 0, I2_BANK = 2, I2_ADDR = 0;
  localparam int I4_BANK = 0, I4_ADDR = 1, I512_BANK = 0, I512_ADDR = 128;
`endif

  int n_chk = 0, n_bad = 0;
  int wr_cnt = 0, st_cnt = 0, s_wr = 0, s_st = 0;
  logic [15:0] mem [0:3][0:255];
  logic [1:0]  log_bank [0:1023];
  logic [7:0]  log_addr [0:1023];
  logic [15:0] log_data [0:1023];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bank_of(input logic [3:0] w);
    return w[1] ? 1 : w[2] ? 2 : w[3] ? 3 : 0;
  endfunction

  function automatic logic [9:0] ref_map(input int i);
    logic [9:0] v, r;
    v = 10'(i);
`ifdef FHT_LOADER_BITREV_EN
    for (int k = 0; k < 10; k++) r[k] = v[9-k];
`else
    r = v;
`endif
    return r;
  endfunction

  function automatic int mem_bad();
    int b = 0;
    logic [9:0] m;
    for (int i = 0; i < 1024; i++) begin
      m = ref_map(i);
      if (mem[m[1:0]][m[9:2]] !== 16'(i)) b++;
    end
    return b;
  endfunction

  task automatic clear_log();
    wr_cnt = 0;
    st_cnt = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = 16'hFFFF;
  endtask

  task automatic chk_log(input string tag, input int n, input int bank, input int adr);
    chk({tag, "_bank"}, log_bank[n], bank);
    chk({tag, "_addr"}, log_addr[n], adr);
    chk({tag, "_data"}, log_data[n], n);
  endtask

  task automatic send(input int n, input int gap);
    int i = 0;
    int t = 0;
    while (i < n && t < 20000) begin
      @(negedge clk);
      t++;
      valid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      din   = 16'(i);
      if (valid && ready) i++;
    end
    if (i < n) chk("send_timeout", i, n);
  endtask

  // Capture every bank write and start pulse from both instances.
  always @(negedge clk) begin
    if ({we3, we2, we1, we0} != 4'b0) begin
      chk("we_onehot", $countones({we3, we2, we1, we0}), 1);
      mem[bank_of({we3, we2, we1, we0})][addr] <= dwr;
      if (wr_cnt < 1024) begin
        log_bank[wr_cnt] <= 2'(bank_of({we3, we2, we1, we0}));
        log_addr[wr_cnt] <= addr;
        log_data[wr_cnt] <= dwr;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (start) st_cnt <= st_cnt + 1;
    if ({s_we3, s_we2, s_we1, s_we0} != 4'b0) s_wr <= s_wr + 1;
    if (s_start) s_st <= s_st + 1;
  end

  initial begin
    int r_hi;
    int wr_before;
    int t;
    rst_n = 1'b0; valid = 1'b0; fht_rdy = 1'b1; din = '0;
    s_valid = 1'b0; s_fht = 1'b0; s_data = 16'h00A5;
    clear_log();
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_start", start, 0);
    chk("rst_we", {we3, we2, we1, we0}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", dwr, 0);
    chk("rst_fcnt", fcnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // Scenario 1: back-to-back frame, value = index
    send(1024, 0);
    @(posedge clk); #1;
    chk("last_we3", we3, 1);
    chk("last_addr", addr, 255);
    chk("last_data", dwr, 1023);
    chk("ready_drop", ready, 0);
    chk("start_early", start, 0);
    @(posedge clk); #1;
    chk("start_pulse", start, 1);
    chk("flush_we", {we3, we2, we1, we0}, 0);
    chk("data_hold", dwr, 1023);
    @(posedge clk); #1;
    chk("start_end", start, 0);
    chk("fcnt_1", fcnt, 1);
    valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("s1_writes", wr_cnt, 1024);
    chk("s1_starts", st_cnt, 1);
    chk_log("idx0", 0, 0, 0);
    chk_log("idx1", 1, I1_BANK, I1_ADDR);
    chk_log("idx2", 2, I2_BANK, I2_ADDR);
    chk_log("idx4", 4, I4_BANK, I4_ADDR);
    chk_log("idx512", 512, I512_BANK, I512_ADDR);
    chk_log("idx1023", 1023, 3, 255);
    chk("s1_mem", mem_bad(), 0);

    // Scenario 2: random gaps
    clear_log();
    fht_rdy = 1'b0;
    repeat (2) @(negedge clk);
    fht_rdy = 1'b1;
    send(1024, 50);
    @(negedge clk) valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("s2_writes", wr_cnt, 1024);
    chk("s2_starts", st_cnt, 1);
    chk("s2_mem", mem_bad(), 0);
    chk("fcnt_2", fcnt, 2);

    // Scenario 3: hold-off until the transform reports done
    valid = 1'b1; din = 16'h1234;
    wr_before = wr_cnt;
    r_hi = 0;
    repeat (5) begin @(posedge clk); #1; if (ready) r_hi++; end
    fht_rdy = 1'b0;
    repeat (300) begin @(posedge clk); #1; if (ready) r_hi++; end
    chk("ready_hold", r_hi, 0);
    chk("ignored_wr", wr_cnt, wr_before);
    valid = 1'b0;
    fht_rdy = 1'b1;
    @(posedge clk); #1;
    chk("ready_back", ready, 1);
    chk("busy_load", busy, 0);
    chk("no_2nd_start", st_cnt, 1);

    // Scenario 4: reset mid-frame
    send(500, 0);
    @(negedge clk); rst_n = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_we", {we3, we2, we1, we0}, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_data", dwr, 0);
    chk("mid_rst_fcnt", fcnt, 0);
    clear_log();
    @(negedge clk) rst_n = 1'b1;
    send(1024, 0);
    @(negedge clk) valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_log("s4_first", 0, 0, 0);
    chk("s4_writes", wr_cnt, 1024);
    chk("s4_starts", st_cnt, 1);
    chk("s4_fcnt", fcnt, 1);
    chk("s4_mem", mem_bad(), 0);

    // Scenario 5: 256 frames on the 16-point instance, counter wrap
    s_valid = 1'b1;
    s_fht = 1'b1;
    for (int f = 0; f < 256; f++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!s_start && t < 200);
      if (!s_start) chk("s_start_timeout", t, 0);
      if (f == 0) chk("s_fcnt_first", s_fcnt, 0);
      if (f == 255) begin
        chk("s_fcnt_255", s_fcnt, 255);
        s_valid = 1'b0;
      end
      s_fht = 1'b0;
      repeat (2) @(negedge clk);
      s_fht = 1'b1;
    end
    repeat (4) @(posedge clk); #1;
    chk("s_fcnt_wrap", s_fcnt, 0);
    chk("s_starts", s_st, 256);
    chk("s_writes", s_wr, 4096);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
